// File: rtl/keypad_encoder.sv
// Keypad front end: synchronizes and debounces ten digit buttons into a
// 4-bit key code (digit+1, 0 = idle) with multi-key rejection.
module keypad_encoder #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] keys_raw,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       multi_err
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEB_PRESS,
        S_PRESSED,
        S_DEB_RELEASE
    } state_t;

    logic [9:0]    r_s1;
    logic [9:0]    r_s2;
    state_t        r_state;
    logic [3:0]    r_cand;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_code;
    logic          r_valid;
    logic          r_multi;

    state_t        w_state_nxt;
    logic [3:0]    w_cand_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [3:0]    w_code_nxt;
    logic          w_valid_nxt;

    logic [9:0]    w_sample;
    logic          w_any;
    logic          w_multi;
    logic          w_one;
    logic [3:0]    w_idx;
    logic [9:0]    w_cand_oh;
    logic          w_match;
    logic          w_last;

    assign w_sample  = r_s2;
    assign w_any     = |w_sample;
    // Clearing the lowest set bit leaves something only if 2+ bits are set
    assign w_multi   = |(w_sample & (w_sample - 10'd1));
    assign w_one     = w_any & ~w_multi;
    assign w_cand_oh = 10'd1 << r_cand;
    assign w_match   = (w_sample == w_cand_oh);
    assign w_last    = (r_cnt == LAST);

    always_comb begin
        w_idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (w_sample[i]) begin
                w_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= keys_raw;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_multi <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
            r_code  <= w_code_nxt;
            r_valid <= w_valid_nxt;
            r_multi <= w_multi;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_code;
        w_valid_nxt = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_one) begin
                    w_cand_nxt  = w_idx;
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = S_DEB_PRESS;
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            S_DEB_PRESS: begin
                if (w_match) begin
                    if (w_last) begin
                        w_state_nxt = S_PRESSED;
                        w_code_nxt  = r_cand + 4'd1;
                        w_valid_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            S_PRESSED: begin
                // Extra or changed keys are ignored until a full release
                if (!w_any) begin
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = S_DEB_RELEASE;
                end
            end
            S_DEB_RELEASE: begin
                if (!w_any) begin
                    if (w_last) begin
                        w_code_nxt  = 4'd0;
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end else begin
                    w_state_nxt = S_PRESSED;
                    w_cnt_nxt   = '0;
                end
            end
        endcase
    end

    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign multi_err = r_multi;

endmodule
